// File: rtl/mult_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// mult_hilo_ctrl
//
// Sequencer for the shared 32x32 unsigned multiplier in the EX stage. It owns
// the architectural HI/LO pair and executes MULT, MULTU, MTHI, MTLO, MFHI and
// MFLO. While a product is settling in the external multi-cycle multiplier,
// the pipeline is held by dropping op_ready.
//
// Signed MULT is done in sign-magnitude form. The magnitudes |a| and |b| go to
// the unsigned multiplier. The 64-bit product is negated on writeback when the
// operand signs differ.
//
// Ports
//   clk       in   1   clock, rising edge
//   reset     in   1   asynchronous, active-high reset
//   op_valid  in   1   operation presented this cycle
//   op        in   3   0 MULT, 1 MULTU, 2 MTHI, 3 MTLO, 4 MFHI, 5 MFLO, 6/7 reserved
//   rs_val    in   32  operand a; also the source for MTHI/MTLO
//   rt_val    in   32  operand b
//   flush     in   1   squash the in-flight multiply or the presented op
//   op_ready  out  1   op accepted at this edge when op_valid & op_ready
//   busy      out  1   multiply in flight (= !op_ready)
//   mf_valid  out  1   one-cycle pulse: mf_data holds the MFHI/MFLO result
//   mf_data   out  32  registered HI or LO value
//   hi        out  32  architectural HI register
//   lo        out  32  architectural LO register
//   mul_a     out  32  multiplier input a, stable while busy
//   mul_b     out  32  multiplier input b, stable while busy
//   mul_p     in   64  unsigned product mul_a*mul_b from the external multiplier
//
// Parameters
//   LATENCY   cycles mul_p needs to settle after mul_a/mul_b change (1..15)
//   CNT_W     settle counter width; must hold LATENCY-1
// -----------------------------------------------------------------------------
module mult_hilo_ctrl #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        op_ready,
  output logic        busy,
  output logic        mf_valid,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_mf_data;
  logic               r_mf_valid;
  logic [31:0]        r_mul_a;
  logic [31:0]        r_mul_b;

  logic               w_take;
  logic [63:0]        w_prod;

  // Two's-complement magnitude. 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  // 64-bit two's-complement negation, modulo 2^64.
  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // op_ready depends on state only, so it never forms a path from op_valid.
  assign op_ready = (r_state == S_IDLE);
  assign busy     = (r_state == S_BUSY);

  // A flush in IDLE squashes the presented op before it is accepted.
  assign w_take = op_valid && !flush && (r_state == S_IDLE);

  always_comb begin
    w_prod = mul_p;
    if (r_neg) begin
      w_prod = neg64(mul_p);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mf_data  <= '0;
      r_mf_valid <= 1'b0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
    end else begin
      r_mf_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            case (op)
              OP_MULT: begin
                r_mul_a <= mag32(rs_val);
                r_mul_b <= mag32(rt_val);
                r_neg   <= rs_val[31] ^ rt_val[31];
                r_cnt   <= CNT_LOAD;
                r_state <= S_BUSY;
              end
              OP_MULTU: begin
                r_mul_a <= rs_val;
                r_mul_b <= rt_val;
                r_neg   <= 1'b0;
                r_cnt   <= CNT_LOAD;
                r_state <= S_BUSY;
              end
              OP_MTHI: r_hi <= rs_val;
              OP_MTLO: r_lo <= rs_val;
              OP_MFHI: begin
                r_mf_data  <= r_hi;
                r_mf_valid <= 1'b1;
              end
              OP_MFLO: begin
                r_mf_data  <= r_lo;
                r_mf_valid <= 1'b1;
              end
              default: begin
                // Reserved encodings are accepted and do nothing.
              end
            endcase
          end
        end
        S_BUSY: begin
          // Flush beats the final-cycle writeback: HI/LO stay untouched.
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mf_valid = r_mf_valid;
  assign mf_data  = r_mf_data;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign mul_a    = r_mul_a;
  assign mul_b    = r_mul_b;

endmodule
